// File: rtl/spatz_pkg.sv
// Shared VRF write-port types for the Spatz vector unit, including the
// write-back buffer entry format.
package spatz_pkg;

  localparam int unsigned VRFAddrWidth = 10;
  localparam int unsigned VRFDataWidth = 64;
  localparam int unsigned VRFBeWidth   = VRFDataWidth / 8;

  typedef logic [VRFAddrWidth-1:0] vreg_addr_t;
  typedef logic [VRFDataWidth-1:0] vreg_data_t;
  typedef logic [VRFBeWidth-1:0]   vreg_be_t;

  typedef struct packed {
    vreg_addr_t addr;
    vreg_data_t data;
    vreg_be_t   be;
  } vrf_wentry_t;

  // Pointer width for a circular buffer; a single-entry buffer still gets one bit.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 32'd1) ? $clog2(depth) : 32'd1;
  endfunction

endpackage

// File: rtl/spatz_vrf_wbuf_fifo.sv
// Depth-entry circular FIFO of VRF write entries; exposes per-slot valid bits
// and addresses so the parent can run a hazard compare over everything pending.
module spatz_vrf_wbuf_fifo
  import spatz_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  vrf_wentry_t              wentry_i,
  output vrf_wentry_t              head_o,
  output vreg_addr_t [Depth-1:0]   addrs_o,
  output logic [Depth-1:0]         valid_o,
  output logic                     empty_o,
  output logic                     full_o
);

  localparam int unsigned PtrWidth = ptr_width(Depth);
  localparam int unsigned CntW     = $clog2(Depth) + 1;

  typedef logic [PtrWidth-1:0] ptr_t;

  ptr_t                    wptr_r;
  ptr_t                    rptr_r;
  logic [CntW-1:0]         count_r;
  logic [Depth-1:0]        valid_r;
  logic [Depth-1:0]        valid_next_s;
  vrf_wentry_t [Depth-1:0] mem_r;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(Depth - 1)) ? ptr_t'(0) : p + ptr_t'(1);
  endfunction

  // Per-slot valid update; push and pop never target the same occupied slot.
  always_comb begin
    valid_next_s = valid_r;
    for (int unsigned i = 0; i < Depth; i++) begin
      if (push_i && (wptr_r == ptr_t'(i))) begin
        valid_next_s[i] = 1'b1;
      end else if (pop_i && (rptr_r == ptr_t'(i))) begin
        valid_next_s[i] = 1'b0;
      end else begin
        valid_next_s[i] = valid_r[i];
      end
    end
  end

  // Pointer, occupancy and valid-bit state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_r  <= ptr_t'(0);
      rptr_r  <= ptr_t'(0);
      count_r <= CntW'(0);
      valid_r <= {Depth{1'b0}};
    end else begin
      if (push_i) begin
        wptr_r <= ptr_inc(wptr_r);
      end
      if (pop_i) begin
        rptr_r <= ptr_inc(rptr_r);
      end
      case ({push_i, pop_i})
        2'b10:   count_r <= count_r + CntW'(1);
        2'b01:   count_r <= count_r - CntW'(1);
        default: count_r <= count_r;
      endcase
      valid_r <= valid_next_s;
    end
  end

  // Entry storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_r[wptr_r] <= wentry_i;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < Depth; i++) begin
      addrs_o[i] = mem_r[i].addr;
    end
  end

  assign head_o  = mem_r[rptr_r];
  assign valid_o = valid_r;
  assign empty_o = (count_r == CntW'(0));
  assign full_o  = (count_r == CntW'(Depth));

endmodule

// File: rtl/spatz_vrf_wbuf.sv
// VRF write-back buffer: absorbs bank-conflict stalls and offers a hazard lookup.
// Optional zero-latency empty-buffer bypass under SPATZ_VRF_WBUF_BYPASS_EN.
module spatz_vrf_wbuf
  import spatz_pkg::*;
#(
  parameter int unsigned Depth    = 2,
  parameter int unsigned CntWidth = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  vreg_addr_t          in_addr_i,
  input  vreg_data_t          in_data_i,
  input  vreg_be_t            in_be_i,
  output logic                vrf_we_o,
  output vreg_addr_t          vrf_waddr_o,
  output vreg_data_t          vrf_wdata_o,
  output vreg_be_t            vrf_wbe_o,
  input  logic                vrf_wvalid_i,
  input  vreg_addr_t          chk_addr_i,
  output logic                chk_hit_o,
  output logic                empty_o,
  output logic [CntWidth-1:0] stall_cnt_o
);

  vrf_wentry_t            in_entry_s;
  vrf_wentry_t            head_s;
  vrf_wentry_t            out_entry_s;
  vreg_addr_t [Depth-1:0] addrs_s;
  logic [Depth-1:0]       valid_s;
  logic                   fifo_empty_s;
  logic                   fifo_full_s;
  logic                   bypass_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   we_s;
  logic                   hit_s;
  logic [CntWidth-1:0]    stall_cnt_r;

  assign in_entry_s = '{addr: in_addr_i, data: in_data_i, be: in_be_i};

`ifdef SPATZ_VRF_WBUF_BYPASS_EN
  assign bypass_s = fifo_empty_s & in_valid_i;
`else
  assign bypass_s = 1'b0;
`endif

  // in_ready depends only on occupancy, so a full buffer refuses even while popping.
  assign in_ready_o = ~fifo_full_s;
  assign push_s     = in_valid_i & in_ready_o & ~(bypass_s & vrf_wvalid_i);
  assign pop_s      = ~fifo_empty_s & vrf_wvalid_i;

  spatz_vrf_wbuf_fifo #(
    .Depth (Depth)
  ) i_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push_i   (push_s),
    .pop_i    (pop_s),
    .wentry_i (in_entry_s),
    .head_o   (head_s),
    .addrs_o  (addrs_s),
    .valid_o  (valid_s),
    .empty_o  (fifo_empty_s),
    .full_o   (fifo_full_s)
  );

  // VRF port source: buffered head first, else the bypassed request, else idle zeros.
  always_comb begin
    we_s        = 1'b0;
    out_entry_s = '0;
    if (!fifo_empty_s) begin
      we_s        = 1'b1;
      out_entry_s = head_s;
    end else if (bypass_s) begin
      we_s        = 1'b1;
      out_entry_s = in_entry_s;
    end else begin
      we_s        = 1'b0;
      out_entry_s = '0;
    end
  end

  // Hazard lookup over every valid entry, including a head that is popping now.
  always_comb begin
    hit_s = bypass_s && (in_addr_i == chk_addr_i);
    for (int unsigned i = 0; i < Depth; i++) begin
      if (valid_s[i] && (addrs_s[i] == chk_addr_i)) begin
        hit_s = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Saturating count of cycles where the VRF withholds the grant.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_r <= CntWidth'(0);
    end else if (we_s && !vrf_wvalid_i && (stall_cnt_r != {CntWidth{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CntWidth'(1);
    end
  end

  assign vrf_we_o    = we_s;
  assign vrf_waddr_o = out_entry_s.addr;
  assign vrf_wdata_o = out_entry_s.data;
  assign vrf_wbe_o   = out_entry_s.be;
  assign chk_hit_o   = hit_s;
  assign empty_o     = fifo_empty_s;
  assign stall_cnt_o = stall_cnt_r;

endmodule

// File: tb/tb_spatz_vrf_wbuf.sv
// Scoreboard bench for spatz_vrf_wbuf: a queue model of pending writes is
// checked every cycle against the DUT, with directed phases then random traffic.
module tb_spatz_vrf_wbuf;
  import spatz_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = 4;
  localparam int          SMAX  = (1 << CW) - 1;
`ifdef SPATZ_VRF_WBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready_o;
  vreg_addr_t    in_addr = '0;
  vreg_data_t    in_data = '0;
  vreg_be_t      in_be = '0;
  logic          vrf_we_o;
  vreg_addr_t    vrf_waddr_o;
  vreg_data_t    vrf_wdata_o;
  vreg_be_t      vrf_wbe_o;
  logic          vrf_wvalid = 1'b0;
  vreg_addr_t    chk_addr = '0;
  logic          chk_hit_o;
  logic          empty_o;
  logic [CW-1:0] stall_cnt_o;

  spatz_vrf_wbuf #(.Depth(DEPTH), .CntWidth(CW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready_o),
    .in_addr_i    (in_addr),
    .in_data_i    (in_data),
    .in_be_i      (in_be),
    .vrf_we_o     (vrf_we_o),
    .vrf_waddr_o  (vrf_waddr_o),
    .vrf_wdata_o  (vrf_wdata_o),
    .vrf_wbe_o    (vrf_wbe_o),
    .vrf_wvalid_i (vrf_wvalid),
    .chk_addr_i   (chk_addr),
    .chk_hit_o    (chk_hit_o),
    .empty_o      (empty_o),
    .stall_cnt_o  (stall_cnt_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  vrf_wentry_t pend_q[$];
  int stall_m = 0;

  function automatic void cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Monitor: model of pending writes, sampled mid-cycle with inputs stable.
  always @(negedge clk) begin
    vrf_wentry_t e;
    bit byp, hit, we_m, acc;
    if (!rst_ni) begin
      pend_q.delete();
      stall_m = 0;
      cmp("rst_we", 64'(vrf_we_o), 64'd0);
      cmp("rst_empty", 64'(empty_o), 64'd1);
      cmp("rst_ready", 64'(in_ready_o), 64'd1);
      cmp("rst_hit", 64'(chk_hit_o), 64'd0);
      cmp("rst_stall", 64'(stall_cnt_o), 64'd0);
    end else begin
      byp  = BYP && (pend_q.size() == 0) && in_valid;
      we_m = (pend_q.size() != 0) || byp;
      acc  = in_valid && (pend_q.size() != DEPTH);
      hit  = byp && (chk_addr == in_addr);
      foreach (pend_q[i]) begin
        if (pend_q[i].addr == chk_addr) hit = 1'b1;
      end
      cmp("we", 64'(vrf_we_o), 64'(we_m));
      cmp("empty", 64'(empty_o), 64'(pend_q.size() == 0));
      cmp("ready", 64'(in_ready_o), 64'(pend_q.size() != DEPTH));
      cmp("hit", 64'(chk_hit_o), 64'(hit));
      cmp("stall", 64'(stall_cnt_o), 64'(stall_m));
      if (pend_q.size() != 0) e = pend_q[0];
      else if (byp) e = '{in_addr, in_data, in_be};
      else e = '0;
      cmp("waddr", 64'(vrf_waddr_o), 64'(e.addr));
      cmp("wdata", vrf_wdata_o, e.data);
      cmp("wbe", 64'(vrf_wbe_o), 64'(e.be));
      if (we_m && vrf_wvalid && (pend_q.size() != 0)) void'(pend_q.pop_front());
      if (acc && !(byp && vrf_wvalid)) pend_q.push_back('{in_addr, in_data, in_be});
      if (we_m && !vrf_wvalid && (stall_m < SMAX)) stall_m++;
    end
  end

  task automatic step(input bit v, input vreg_addr_t a, input vreg_data_t d,
                      input bit g, input vreg_addr_t c);
    in_valid   = v;
    in_addr    = a;
    in_data    = d;
    in_be      = d[7:0] ^ 8'h5A;
    vrf_wvalid = g;
    chk_addr   = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
  endtask

  initial begin
    bit v, acc;
    vreg_addr_t a;
    vreg_data_t d;
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;

    // Single write with grant always high.
    step(1'b1, 10'h010, 64'hA5A5A5A5A5A5A5A5, 1'b1, 10'h010);
    step(1'b0, 10'h000, 64'h0, 1'b1, 10'h010);
    step(1'b0, 10'h000, 64'h0, 1'b1, 10'h010);

    // Grant withheld: third push stalls, then in-order drain.
    step(1'b1, 10'h010, 64'h1111, 1'b0, 10'h000);
    step(1'b1, 10'h014, 64'h2222, 1'b0, 10'h000);
    repeat (4) step(1'b1, 10'h018, 64'h3333, 1'b0, 10'h000);
    cmp("stall5", 64'(stall_cnt_o), BYP ? 64'd6 : 64'd5);
    step(1'b1, 10'h018, 64'h3333, 1'b1, 10'h000);
    step(1'b1, 10'h018, 64'h3333, 1'b1, 10'h000);
    repeat (2) step(1'b0, 10'h000, 64'h0, 1'b1, 10'h000);

    // Full buffer with a one-cycle grant and a concurrent push.
    step(1'b1, 10'h040, 64'h4040, 1'b0, 10'h000);
    step(1'b1, 10'h044, 64'h4444, 1'b0, 10'h000);
    step(1'b1, 10'h048, 64'h4848, 1'b1, 10'h000);
    step(1'b1, 10'h048, 64'h4848, 1'b0, 10'h000);
    repeat (3) step(1'b0, 10'h000, 64'h0, 1'b1, 10'h000);

    // Hazard lookup.
    step(1'b1, 10'h020, 64'h2020, 1'b0, 10'h024);
    step(1'b1, 10'h024, 64'h2424, 1'b0, 10'h024);
    step(1'b0, 10'h000, 64'h0, 1'b0, 10'h024);
    step(1'b0, 10'h000, 64'h0, 1'b0, 10'h028);
    repeat (3) step(1'b0, 10'h000, 64'h0, 1'b1, 10'h024);

    // Reset with two entries pending drops them asynchronously.
    step(1'b1, 10'h050, 64'h5050, 1'b0, 10'h000);
    step(1'b1, 10'h054, 64'h5454, 1'b0, 10'h000);
    in_valid = 1'b0;
    rst_ni   = 1'b0;
    #1;
    cmp("async_we", 64'(vrf_we_o), 64'd0);
    cmp("async_empty", 64'(empty_o), 64'd1);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    step(1'b0, 10'h000, 64'h0, 1'b1, 10'h000);

    // Stall counter saturation.
    step(1'b1, 10'h060, 64'h6060, 1'b0, 10'h000);
    repeat (20) step(1'b0, 10'h000, 64'h0, 1'b0, 10'h000);
    cmp("stall_sat", 64'(stall_cnt_o), 64'(SMAX));
    repeat (2) step(1'b0, 10'h000, 64'h0, 1'b1, 10'h000);
    do_reset();

`ifdef SPATZ_VRF_WBUF_BYPASS_EN
    step(1'b1, 10'h030, 64'h3030, 1'b1, 10'h030);
    step(1'b0, 10'h000, 64'h0, 1'b1, 10'h030);
`endif

    // Random traffic; producer holds each request until accepted.
    v = 1'b0;
    acc = 1'b0;
    a = '0;
    d = '0;
    for (int n = 0; n < 600; n++) begin
      if (!v || acc) begin
        v = ($urandom_range(0, 3) != 0);
        a = 10'h100 + vreg_addr_t'(4 * $urandom_range(0, 3));
        d = {$urandom, $urandom};
      end
      in_valid   = v;
      in_addr    = a;
      in_data    = d;
      in_be      = d[15:8];
      vrf_wvalid = (n % 100 < 50) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      chk_addr   = 10'h100 + vreg_addr_t'(4 * $urandom_range(0, 4));
      @(negedge clk);
      acc = v && in_ready_o;
      @(posedge clk);
      #1;
      if (n == 300) do_reset();
    end

    repeat (4) step(1'b0, 10'h000, 64'h0, 1'b1, 10'h000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
